// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready register chain of DEPTH stages; stalls propagate backward, bubbles collapse forward.
// Optional synchronous flush port enabled by defining PIPE_REG_CHAIN_FLUSH_EN.
module pipe_reg_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
`ifdef PIPE_REG_CHAIN_FLUSH_EN
    input  logic                         flush,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
    localparam int LAST = DEPTH - 1;

    generate
        if (DEPTH < 1) begin : g_depth_check
            $error("pipe_reg_chain: DEPTH must be at least 1");
        end
    endgenerate

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] dat [DEPTH];
    logic             flush_now;
    logic             in_xfer;
    logic             out_xfer;

`ifdef PIPE_REG_CHAIN_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // A stage may load when it is empty or its content moves on; this ripples from the output.
    always_comb begin : adv_chain
        logic carry;
        adv   = '0;
        carry = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = ~vld[i] | carry;
            carry  = adv[i];
        end
    end

    assign in_ready  = adv[0] & ~flush_now;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = vld[LAST];
    assign out_data  = dat[LAST];
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld       <= '0;
            occupancy <= '0;
        end else if (flush_now) begin
            vld       <= '0;
            occupancy <= '0;
        end else begin
            if (adv[0]) begin
                vld[0] <= in_xfer;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    vld[i] <= vld[i-1];
                end
            end
            if (in_xfer && !out_xfer) begin
                occupancy <= occupancy + OCC_ONE;
            end else if (!in_xfer && out_xfer) begin
                occupancy <= occupancy - OCC_ONE;
            end
        end
    end

    // Data only loads behind a valid qualifier, so bubbles leave stale contents in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= RESET_VAL;
            end
        end else if (!flush_now) begin
            if (adv[0] && in_xfer) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i] && vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a DEPTH=4/WIDTH=8 chain and a DEPTH=1/WIDTH=32 chain, each checked
// every cycle against a word-position model, plus directed streaming/backpressure/bubble/reset/flush cases.
module tb_pipe_reg_chain;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [2:0] a_occupancy;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [0:0]  b_occupancy;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_d4 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
`ifdef PIPE_REG_CHAIN_FLUSH_EN
        .flush(flush),
`endif
        .occupancy(a_occupancy)
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
`ifdef PIPE_REG_CHAIN_FLUSH_EN
        .flush(flush),
`endif
        .occupancy(b_occupancy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: ordered list of in-flight words (oldest first) with the stage each one occupies.
    int          m_cnt [2];
    int          m_pos [2][8];
    logic [31:0] m_val [2][8];
    logic [31:0] m_top [2];
    bit          m_acc [2];

    function automatic int dep(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [31:0] msk(input int k);
        return (k == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_acc[k] = 1'b0;
            m_top[k] = (k == 0) ? 32'hA5 : 32'h0;
        end
    endfunction

    // Each word moves one stage forward unless the word ahead of it is in the way;
    // the oldest word leaves from the last stage when the consumer is ready.
    function automatic void m_plan(input int k, input bit ordy, input bit fl,
                                   output int np [8], output bit ir);
        int d;
        int cand;
        d = dep(k);
        for (int e = 0; e < 8; e++) np[e] = 0;
        for (int e = 0; e < m_cnt[k]; e++) begin
            if (e == 0) begin
                if (m_pos[k][0] == d - 1) np[0] = ordy ? d : d - 1;
                else np[0] = m_pos[k][0] + 1;
            end else begin
                cand  = m_pos[k][e] + 1;
                np[e] = (cand < np[e-1] - 1) ? cand : np[e-1] - 1;
            end
        end
        ir = (m_cnt[k] == 0) || (m_pos[k][m_cnt[k]-1] != 0) || (np[m_cnt[k]-1] == 1);
        ir = ir && !fl;
    endfunction

    function automatic void m_step(input int k, input bit iv, input logic [31:0] idat,
                                   input bit ordy, input bit fl);
        int np [8];
        bit ir;
        int n;
        int d;
        d = dep(k);
        m_plan(k, ordy, fl, np, ir);
        m_acc[k] = iv && ir;
        if (fl) begin
            m_cnt[k] = 0;
            return;
        end
        n = 0;
        for (int e = 0; e < m_cnt[k]; e++) begin
            if (np[e] < d) begin
                if (np[e] == d - 1 && m_pos[k][e] != d - 1) m_top[k] = m_val[k][e];
                m_pos[k][n] = np[e];
                m_val[k][n] = m_val[k][e];
                n++;
            end
        end
        if (m_acc[k]) begin
            m_pos[k][n] = 0;
            m_val[k][n] = idat & msk(k);
            if (d == 1) m_top[k] = idat & msk(k);
            n++;
        end
        m_cnt[k] = n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reset();
        end else begin
            m_step(0, a_in_valid, {24'h0, a_in_data}, a_out_ready, flush);
            m_step(1, b_in_valid, b_in_data, b_out_ready, flush);
        end
    end

    task automatic check_model(input int k, input logic ir_got, input logic ov_got,
                               input logic [31:0] od_got, input logic [31:0] occ_got,
                               input logic ordy);
        int np [8];
        bit ir;
        bit ov;
        m_plan(k, ordy, flush, np, ir);
        ov = (m_cnt[k] > 0) && (m_pos[k][0] == dep(k) - 1);
        chk($sformatf("model_in_ready[%0d]", k), 32'(ir_got), 32'(ir));
        chk($sformatf("model_out_valid[%0d]", k), 32'(ov_got), 32'(ov));
        chk($sformatf("model_out_data[%0d]", k), od_got, m_top[k]);
        chk($sformatf("model_occupancy[%0d]", k), occ_got, 32'(m_cnt[k]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_model(0, a_in_ready, a_out_valid, {24'h0, a_out_data}, {29'h0, a_occupancy}, a_out_ready);
            check_model(1, b_in_ready, b_out_valid, b_out_data, {31'h0, b_occupancy}, b_out_ready);
            chk("d1_ready_rule", 32'(b_in_ready), 32'(!b_out_valid || b_out_ready));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] got  [32];
    int         gott [32];
    int         ngot;
    logic [7:0] exp_bp [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 32'h0; b_out_ready = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // reset state, rst still high
        @(negedge clk);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'hA5);
        chk("rst_occupancy", 32'(a_occupancy), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // streaming 01..10 with out_ready held high
        a_out_ready = 1'b1;
        ngot = 0;
        for (int t = 0; t < 24; t++) begin
            a_in_valid = (t < 16);
            a_in_data  = (t < 16) ? 8'(t + 1) : 8'h00;
            @(negedge clk);
            if (a_out_valid && a_out_ready && ngot < 32) begin
                got[ngot]  = a_out_data;
                gott[ngot] = t;
                ngot++;
            end
            if (t == 10) chk("stream_occupancy", 32'(a_occupancy), 32'd4);
            @(posedge clk);
            #1;
        end
        chk("stream_count", 32'(ngot), 32'd16);
        chk("stream_first_latency", 32'(gott[0]), 32'd4);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("stream_data_%0d", i), 32'(got[i]), 32'(i + 1));
            chk($sformatf("stream_cycle_%0d", i), 32'(gott[i]), 32'(4 + i));
        end

        // backpressure and fill
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h11; tick();
        a_in_data = 8'h22; tick();
        a_in_data = 8'h33; tick();
        a_in_data = 8'h44; tick();
        a_in_data = 8'h55;
        @(negedge clk);
        chk("bp_full_occupancy", 32'(a_occupancy), 32'd4);
        chk("bp_full_in_ready", 32'(a_in_ready), 32'd0);
        chk("bp_full_head", 32'(a_out_data), 32'h11);
        tick();
        @(negedge clk);
        chk("bp_hold_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_head", 32'(a_out_data), 32'h11);
        chk("bp_release_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 1'b0;
        exp_bp[0] = 8'h22; exp_bp[1] = 8'h33; exp_bp[2] = 8'h44; exp_bp[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp_drain_data_%0d", i), 32'(a_out_data), 32'(exp_bp[i]));
            chk($sformatf("bp_drain_valid_%0d", i), 32'(a_out_valid), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("bp_empty_valid", 32'(a_out_valid), 32'd0);
        chk("bp_empty_occupancy", 32'(a_occupancy), 32'd0);
        tick();

        // bubble collapse
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'hC1; tick();
        a_in_valid = 1'b0; tick(); tick();
        a_in_valid = 1'b1; a_in_data = 8'hC2; tick();
        a_in_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("bubble_occupancy", 32'(a_occupancy), 32'd2);
        tick();
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bubble_first", 32'(a_out_data), 32'hC1);
        chk("bubble_first_valid", 32'(a_out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("bubble_second", 32'(a_out_data), 32'hC2);
        chk("bubble_second_valid", 32'(a_out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("bubble_done_valid", 32'(a_out_valid), 32'd0);
        tick();

        // asynchronous reset in the middle of a cycle with words in flight
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h71; tick();
        a_in_data = 8'h72; tick();
        a_in_data = 8'h73; tick();
        a_in_valid = 1'b0;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
        chk("midrst_out_data", 32'(a_out_data), 32'hA5);
        chk("midrst_occupancy", 32'(a_occupancy), 32'd0);
        chk("midrst_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();

`ifdef PIPE_REG_CHAIN_FLUSH_EN
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h61; tick();
        a_in_data = 8'h62; tick();
        a_in_data = 8'h63; tick();
        a_in_data = 8'hEE;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(a_in_ready), 32'd0);
        chk("flush_pre_occupancy", 32'(a_occupancy), 32'd3);
        tick();
        flush = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("flush_occupancy", 32'(a_occupancy), 32'd0);
        chk("flush_out_valid", 32'(a_out_valid), 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("flush_no_ee_valid_%0d", i), 32'(a_out_valid), 32'd0);
            chk($sformatf("flush_no_ee_data_%0d", i), 32'(a_out_data == 8'hEE), 32'd0);
            tick();
        end
`endif

        // randomized traffic: DEPTH=4 with stall phases, DEPTH=1 with alternating out_ready
        b_in_valid = 1'b1;
        b_in_data  = $urandom;
        for (int c = 0; c < 600; c++) begin
            if (!a_in_valid || m_acc[0]) begin
                a_in_valid = ($urandom % 4) != 0;
                a_in_data  = 8'($urandom);
            end
            if (((c / 50) % 2) == 1) a_out_ready = ($urandom % 4) == 0;
            else a_out_ready = ($urandom % 4) != 0;
            if (m_acc[1]) b_in_data = $urandom;
            b_out_ready = ~b_out_ready;
            tick();
        end

        a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        chk("final_d4_empty", 32'(a_occupancy), 32'd0);
        chk("final_d1_empty", 32'(b_occupancy), 32'd0);
        tick();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
